// File: rtl/serial_subtractor_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | serial_subtractor_pkg                                                |
// | Shared FSM encoding and defaults for the bit-serial subtractor.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/serial_subtractor_full_subtractor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | full_subtractor                                                      |
// | One-bit full subtractor: diff = x - y - bin, with borrow-out.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | serial_subtractor                                                    |
// | Bit-serial d = a - b - bi, LSB first, one full-subtractor cell.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bi,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bo,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic             r_br;
  logic [CNT_W-1:0] r_cnt;

  logic             w_diff;
  logic             w_borrow;

  full_subtractor u_cell (
    .x    (r_a_sr[0]),
    .y    (r_b_sr[0]),
    .bin  (r_br),
    .diff (w_diff),
    .bout (w_borrow)
  );

  // The minuend register doubles as the result register: each consumed
  // minuend bit frees the MSB slot that receives the new difference bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_br    <= 1'b0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      d       <= '0;
      bo      <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a_sr  <= a;
            r_b_sr  <= b;
            r_br    <= bi;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_a_sr <= {w_diff, r_a_sr[WIDTH-1:1]};
          r_b_sr <= {1'b0, r_b_sr[WIDTH-1:1]};
          r_br   <= w_borrow;
          r_cnt  <= r_cnt + C_ONE;
          if (r_cnt == C_LAST) begin
            d       <= {w_diff, r_a_sr[WIDTH-1:1]};
            bo      <= w_borrow;
            // Overflow when the borrow into the MSB differs from the borrow out.
            ovf     <= w_borrow ^ r_br;
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// Self-checking bench for serial_subtractor: cycle model plus directed vectors.
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         bi    = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] d;
  logic         bo;
  logic         ovf;

  int errors = 0;
  int checks = 0;

  logic         m_busy = 1'b0;
  logic         m_done = 1'b0;
  logic [W-1:0] m_d    = '0;
  logic         m_bo   = 1'b0;
  logic         m_ovf  = 1'b0;
  int           m_left = 0;
  logic [W:0]   p_res  = '0;
  logic         p_ovf  = 1'b0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bi    (bi),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .bo    (bo),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [W:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic z);
    int r;
    r = int'(x) - int'(y) - int'(z);
    return r[W:0];
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic z);
    int sx;
    int sy;
    int r;
    sx = (x[W-1]) ? int'(x) - (1 << W) : int'(x);
    sy = (y[W-1]) ? int'(y) - (1 << W) : int'(y);
    r  = sx - sy - int'(z);
    return (r < -(1 << (W - 1))) || (r > (1 << (W - 1)) - 1);
  endfunction

  // Transaction-level model: an accepted start yields done W edges later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_d    <= '0;
      m_bo   <= 1'b0;
      m_ovf  <= 1'b0;
      m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (m_left == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_d    <= p_res[W-1:0];
          m_bo   <= p_res[W];
          m_ovf  <= p_ovf;
        end
        m_left <= m_left - 1;
      end else if (start) begin
        m_busy <= 1'b1;
        m_left <= W;
        p_res  <= ref_sub(a, b, bi);
        p_ovf  <= ref_ovf(a, b, bi);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check("busy_vs_model", 32'(busy), 32'(m_busy));
    check("done_vs_model", 32'(done), 32'(m_done));
    check("d_vs_model",    32'(d),    32'(m_d));
    check("bo_vs_model",   32'(bo),   32'(m_bo));
    check("ovf_vs_model",  32'(ovf),  32'(m_ovf));
  endtask

  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic z);
    a     = x;
    b     = y;
    bi    = z;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic z, input logic [W-1:0] exp_d, input logic exp_bo,
                        input logic exp_ovf);
    int n;
    start_op(x, y, z);
    n = 1;
    check({name, "_busy"}, 32'(busy), 32'd1);
    while (!done && n < 20) begin
      tick();
      n++;
    end
    check({name, "_done"}, 32'(done), 32'd1);
    check({name, "_latency"}, 32'(n), 32'(W + 1));
    check({name, "_d"},   32'(d),   32'(exp_d));
    check({name, "_bo"},  32'(bo),  32'(exp_bo));
    check({name, "_ovf"}, 32'(ovf), 32'(exp_ovf));
  endtask

  initial begin
    logic [W:0] r;
    logic       v;
    int         n;

    tick();
    tick();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_d",    32'(d),    32'd0);
    check("reset_bo",   32'(bo),   32'd0);
    check("reset_ovf",  32'(ovf),  32'd0);
    rst_n = 1'b1;
    tick();

    run_op("sub_9_3",   4'd9, 4'd3, 1'b0, 4'd6,  1'b0, 1'b1);
    tick();
    run_op("sub_3_9",   4'd3, 4'd9, 1'b0, 4'hA, 1'b1, 1'b1);
    tick();
    run_op("sub_0_0_b", 4'd0, 4'd0, 1'b1, 4'hF, 1'b1, 1'b0);
    tick();
    run_op("sub_8_1",   4'd8, 4'd1, 1'b0, 4'd7,  1'b0, 1'b1);
    tick();

    // Start while busy must be ignored.
    start_op(4'd5, 4'd2, 1'b0);
    tick();
    a     = 4'hF;
    b     = 4'h0;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    check("ignore_done", 32'(done), 32'd1);
    check("ignore_d",    32'(d),    32'd3);
    check("ignore_bo",   32'(bo),   32'd0);
    // Back-to-back start issued in the done cycle.
    run_op("b2b_7_2", 4'd7, 4'd2, 1'b0, 4'd5, 1'b0, 1'b0);
    tick();

    // Asynchronous reset in the middle of a run.
    start_op(4'd5, 4'd2, 1'b0);
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_d",    32'(d),    32'd0);
    check("arst_bo",   32'(bo),   32'd0);
    check("arst_ovf",  32'(ovf),  32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("post_reset_no_done", 32'(done), 32'd0);
    end

    for (int ia = 0; ia < (1 << W); ia++) begin
      for (int ib = 0; ib < (1 << W); ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          r = ref_sub(W'(ia), W'(ib), ic[0]);
          v = ref_ovf(W'(ia), W'(ib), ic[0]);
          run_op("sweep", W'(ia), W'(ib), ic[0], r[W-1:0], r[W], v);
        end
      end
    end
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
